// File: rtl/ram_pkg.sv
// Shared types and mode constants for the single-port RAM controller.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam bit MODE_READ_FIRST  = 1'b1;
  localparam bit MODE_WRITE_FIRST = 1'b0;

endpackage

// File: rtl/ram_sp_array.sv
// Pure single-port storage: one write port and an enabled synchronous read.
// No reset so the array stays inferable as block RAM.
module ram_sp_array #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ADDR_W     = 7,
  parameter bit          READ_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // rdata only moves on re, so it holds a buffered response across sweeps
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      if (!READ_FIRST && we && (waddr == raddr)) begin
        r_rdata <= wdata;
      end else begin
        r_rdata <= r_mem[raddr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: clear-sweep FSM, write-port mux and a
// one-entry response buffer with valid/ready backpressure.
module ram_sp_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned       DATA_W     = 4,
  parameter int unsigned       ADDR_W     = 7,
  parameter bit                READ_FIRST = MODE_READ_FIRST,
  parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clr_req,
  output logic              busy
);

  localparam int unsigned   DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W:0]   r_ptr;
  logic              r_rsp_vld;
  logic              w_req_rdy;
  logic              w_fire;
  logic              w_busy;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_req_rdy   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = req_addr;
    w_wdata     = req_wdata;
    unique case (r_state)
      ST_CLEAR: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_ptr[ADDR_W-1:0];
        w_wdata = INIT_VAL;
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_req_rdy = !r_rsp_vld || rsp_rdy;
        w_we      = req_vld && w_req_rdy && req_we;
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign w_fire = req_vld && w_req_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_ptr <= r_ptr + 1'b1;
    end else begin
      r_ptr <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_vld <= 1'b0;
    end else if (w_fire) begin
      r_rsp_vld <= 1'b1;
    end else if (rsp_rdy) begin
      r_rsp_vld <= 1'b0;
    end
  end

  ram_sp_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .READ_FIRST(READ_FIRST)
  ) u_array (
    .clk  (clk),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(w_wdata),
    .re   (w_fire),
    .raddr(req_addr),
    .rdata(w_rdata)
  );

  // The array output register doubles as the response data buffer; gating
  // with valid keeps the output defined before the first read.
  assign rsp_data = r_rsp_vld ? w_rdata : '0;
  assign rsp_vld  = r_rsp_vld;
  assign req_rdy  = w_req_rdy;
  assign busy     = w_busy;

endmodule
